eq_axil_cfg_sequencer: RTL and testbench

- Single-outstanding AXI4-Lite master that arbitrates register read/write requests from NUM_REQ requesters and sequences them onto one AXI4-Lite slave port.
- Typical requesters: band coefficient updater, host mailbox.
- Sits between the EQ control logic and the 32-bit AXI4-Lite register slave (4 x 32-bit registers at 0x0/0x4/0x8/0xC).

---
 rtl/eq_axil_pkg.sv | 23 ++
 rtl/eq_rr_arbiter.sv | 38 +++
 rtl/eq_axil_cfg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_eq_axil_cfg_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_axil_pkg.sv
// Shared types and constants for the EQ AXI4-Lite configuration sequencer.
package eq_axil_pkg;

  localparam int         AXIL_DATA_W = 32;
  localparam logic [3:0] AXIL_STRB   = 4'hF;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/eq_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requester strictly
// after i_ptr, wrapping to the lowest overall when nothing lies above it.
module eq_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_above;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_pool;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_above
      assign w_above[gi] = (ID_W'(gi) > i_ptr);
    end
  endgenerate

  assign w_masked = i_req & w_above;
  assign w_pool   = (|w_masked) ? w_masked : i_req;
  // Isolate the lowest set bit of the candidate pool.
  assign o_grant  = w_pool & (~w_pool + NUM_REQ'(1));
  assign o_any    = |i_req;

  always_comb begin
    o_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant[k]) o_idx = ID_W'(k);
    end
  end

endmodule

// File: rtl/eq_axil_cfg_sequencer.sv
// Single-outstanding AXI4-Lite master that round-robins register requests
// from NUM_REQ requesters onto one register slave.
module eq_axil_cfg_sequencer
  import eq_axil_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [2:0]                     m_axi_awprot,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [3:0]                     m_axi_wstrb,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [2:0]                     m_axi_arprot,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready
);

  state_t                   r_state;
  logic [ID_W-1:0]          r_ptr;
  logic [ID_W-1:0]          r_id;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic [AXIL_DATA_W-1:0]   r_rdata;
  resp_t                    r_resp;

  logic [NUM_REQ-1:0]       w_grant;
  logic [ID_W-1:0]          w_idx;
  logic                     w_any;
  logic                     w_sel_write;
  logic [ADDR_WIDTH-1:0]    w_sel_addr;
  logic [DATA_WIDTH-1:0]    w_sel_wdata;

  eq_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_write = req_write[k];
        w_sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gated by ARESETN so a held request cannot see a grant while reset is active.
  assign req_ready = (r_state == ST_IDLE && ARESETN) ? w_grant : '0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= ST_IDLE;
      r_ptr     <= ID_W'(NUM_REQ - 1);
      r_id      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= OKAY;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ptr   <= w_idx;
            r_id    <= w_idx;
            r_addr  <= w_sel_addr & ~ADDR_WIDTH'(3);
            r_wdata <= w_sel_wdata;
            if (w_sel_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_AW_W;
            end else begin
              r_state <= ST_RD_AR;
            end
          end
        end
        ST_WR_AW_W: begin
          // AW and W retire independently; leave once both are done.
          if (m_axi_awready) r_awvalid <= 1'b0;
          if (m_axi_wready)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready)) begin
            r_state <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (m_axi_bvalid) begin
            r_rdata <= '0;
            r_resp  <= resp_t'(m_axi_bresp);
            r_state <= ST_RSP;
          end
        end
        ST_RD_AR: begin
          if (m_axi_arready) r_state <= ST_RD_R;
        end
        ST_RD_R: begin
          if (m_axi_rvalid) begin
            r_rdata <= m_axi_rdata;
            r_resp  <= resp_t'(m_axi_rresp);
            r_state <= ST_RSP;
          end
        end
        ST_RSP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid     = (r_state == ST_RSP);
  assign rsp_id        = r_id;
  assign rsp_rdata     = r_rdata;
  assign rsp_resp      = r_resp;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = AXIL_STRB;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = (r_state == ST_WR_B);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (r_state == ST_RD_AR);
  assign m_axi_rready  = (r_state == ST_RD_R);

endmodule

// File: tb/tb_eq_axil_cfg_sequencer.sv
// Scoreboard bench: expectations queued at grant time, checked on rsp_valid,
// against a small 4-register AXI4-Lite slave with stall/error knobs.
module tb_eq_axil_cfg_sequencer;

  localparam int NREQ = 2;
  localparam int AW   = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [NREQ-1:0]   req_valid, req_ready, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic              rsp_valid;
  logic [0:0]        rsp_id;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_axi_awaddr, m_axi_araddr;
  logic [2:0]        m_axi_awprot, m_axi_arprot;
  logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0]       m_axi_wdata, m_axi_rdata;
  logic [3:0]        m_axi_wstrb;
  logic [1:0]        m_axi_bresp, m_axi_rresp;
  logic              m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic              m_axi_rvalid, m_axi_rready;

  eq_axil_cfg_sequencer #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int          w_stall_len = 0;
  bit          slverr_en   = 1'b0;
  bit          b_hold      = 1'b0;
  logic [31:0] smem [4];
  logic        aw_got, w_got;
  logic [3:0]  aw_a;
  logic [31:0] w_d;
  int          w_wait_cnt;
  int          b_count;
  logic        s_aw_now, s_w_now;
  logic [3:0]  s_aw_addr;
  logic [31:0] s_w_data;

  assign m_axi_awready = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_wready  = (w_wait_cnt >= w_stall_len);
  assign s_aw_now  = aw_got | (m_axi_awvalid & m_axi_awready);
  assign s_w_now   = w_got  | (m_axi_wvalid & m_axi_wready);
  assign s_aw_addr = aw_got ? aw_a : m_axi_awaddr;
  assign s_w_data  = w_got  ? w_d  : m_axi_wdata;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'd0;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'd0;
      w_wait_cnt <= 0;
      for (int i = 0; i < 4; i++) smem[i] <= '0;
    end else begin
      if (m_axi_wvalid && !m_axi_wready) w_wait_cnt <= w_wait_cnt + 1;
      else if (m_axi_wvalid) w_wait_cnt <= 0;
      if (m_axi_awvalid && m_axi_awready) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_got <= 1'b1; w_d <= m_axi_wdata; end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
      end else if (s_aw_now && s_w_now && !m_axi_bvalid && !b_hold) begin
        m_axi_bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (slverr_en && s_aw_addr[3:2] == 2'd2) m_axi_bresp <= 2'd2;
        else begin
          m_axi_bresp <= 2'd0;
          smem[s_aw_addr[3:2]] <= s_w_data;
        end
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= smem[m_axi_araddr[3:2]];
        m_axi_rresp  <= 2'd0;
      end else if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) b_count <= 0;
    else if (m_axi_bvalid && m_axi_bready) b_count <= b_count + 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          gcyc;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [4];
  logic [3:0]  exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  bit          lat_chk   = 1'b1;
  int          aw_cycles = 0;
  int          w_wait_seen = 0;

  task automatic push_exp(input int id, input bit wr, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    int   w;
    w      = int'(a[3:2]);
    e.id   = id;
    e.gcyc = cyc;
    e.lat  = lat_chk;
    if (wr) begin
      e.rdata = '0;
      e.resp  = (slverr_en && w == 2) ? 2'd2 : 2'd0;
      if (e.resp == 2'd0) ref_mem[w] = d;
    end else begin
      e.rdata = ref_mem[w];
      e.resp  = 2'd0;
    end
    exp_addr  = {a[3:2], 2'b00};
    exp_wdata = d;
    exp_q.push_back(e);
  endtask

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
      if (m_axi_awvalid) begin
        chk("awaddr", m_axi_awaddr, exp_addr);
        aw_cycles <= aw_cycles + 1;
      end
      if (m_axi_wvalid) begin
        chk("wdata", m_axi_wdata, exp_wdata);
        if (!m_axi_wready) w_wait_seen <= w_wait_seen + 1;
      end
      if (m_axi_arvalid) chk("araddr", m_axi_araddr, exp_addr);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_id", rsp_id, mon_e.id);
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_resp", rsp_resp, mon_e.resp);
          if (mon_e.lat) chk("rsp_latency", cyc - mon_e.gcyc, 3);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int id, input bit v, input bit wr, input logic [3:0] a, input logic [31:0] d);
    req_valid[id]           = v;
    req_write[id]           = wr;
    req_addr[id*AW +: AW]   = a;
    req_wdata[id*32 +: 32]  = d;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int k = 0; k < 300; k++) begin
      if (req_ready != '0) begin
        g = req_ready[1] ? 1 : 0;
        return;
      end
      @(negedge ACLK); #1;
    end
    chk("grant_timeout", 1, 0);
  endtask

  task automatic issue(input int id, input bit wr, input logic [3:0] a, input logic [31:0] d);
    int g;
    set_req(id, 1'b1, wr, a, d);
    #1;
    wait_grant(g);
    if (g >= 0) begin
      chk("grant_id", g, id);
      push_exp(id, wr, a, d);
    end
    @(posedge ACLK); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic dual(input int n, input int first,
                      input bit wr0, input logic [3:0] a0, input logic [31:0] d0,
                      input bit wr1, input logic [3:0] a1, input logic [31:0] d1);
    int g, eg;
    eg = first;
    set_req(0, 1'b1, wr0, a0, d0);
    set_req(1, 1'b1, wr1, a1, d1);
    #1;
    for (int i = 0; i < n; i++) begin
      wait_grant(g);
      if (g < 0) break;
      chk("dual_grant", g, eg);
      if (g == 0) push_exp(0, wr0, a0, d0);
      else        push_exp(1, wr1, a1, d1);
      eg = 1 - g;
      @(posedge ACLK); #1;
    end
    req_valid = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge ACLK);
    if (exp_q.size() != 0) chk("drain_pending", exp_q.size(), 0);
    @(negedge ACLK); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_awvalid"}, m_axi_awvalid, 0);
    chk({tag, "_wvalid"}, m_axi_wvalid, 0);
    chk({tag, "_bready"}, m_axi_bready, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_awaddr"}, m_axi_awaddr, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_wdata"}, m_axi_wdata, 0);
    chk({tag, "_prot"}, {m_axi_awprot, m_axi_arprot}, 0);
    chk({tag, "_wstrb"}, m_axi_wstrb, 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, ww0, b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    chk_quiet("reset");
    ARESETN = 1'b1;
    @(negedge ACLK); #1;

    // requester 0 writes then reads back the four registers
    for (int i = 0; i < 4; i++) issue(0, 1'b1, 4'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 4'(i * 4), 32'h0);
    drain();

    // both requesters continuously valid; pointer last at 0 so 1 goes first
    dual(4, 1, 1'b1, 4'h0, 32'hA5A5_A5A5, 1'b0, 4'h0, 32'h0);
    drain();

    // W channel stalled five cycles, AW accepted immediately
    lat_chk = 1'b0;
    w_stall_len = 5;
    aw0 = aw_cycles; ww0 = w_wait_seen; b0 = b_count;
    issue(0, 1'b1, 4'h4, 32'h1234_5678);
    drain();
    chk("stall_aw_cycles", aw_cycles - aw0, 1);
    chk("stall_w_wait", w_wait_seen - ww0, 5);
    chk("stall_b_count", b_count - b0, 1);
    w_stall_len = 0;
    lat_chk = 1'b1;

    // SLVERR passthrough, then normal traffic resumes
    slverr_en = 1'b1;
    issue(1, 1'b1, 4'h8, 32'hBAD0_0008);
    drain();
    slverr_en = 1'b0;
    issue(0, 1'b0, 4'h8, 32'h0);
    issue(0, 1'b0, 4'h7, 32'h0);
    drain();

    // reset while waiting in WR_B
    b_hold = 1'b1;
    issue(0, 1'b1, 4'hC, 32'hDEAD_BEEF);
    repeat (3) @(negedge ACLK);
    #1;
    chk("in_wr_b", m_axi_bready, 1);
    set_req(0, 1'b1, 1'b0, 4'h4, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'h8, 32'h0);
    #2;
    ARESETN = 1'b0;
    #1;
    chk_quiet("midrst");
    exp_q.delete();
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    b_hold = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    dual(2, 0, 1'b0, 4'h4, 32'h0, 1'b0, 4'h8, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
